bserial_negate_unit: RTL and testbench

//  Byte-serial 32-bit inverter/negator for the ALU execute path. It sits directly

---
 rtl/bserial_negate_unit_if.sv | 24 ++
 rtl/bserial_negate_unit.sv | 87 ++++++++
 tb/tb_bserial_negate_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bserial_negate_unit_if.sv
// Operand/result handshake bundle for the byte-serial NOT/negate unit.
interface bserial_negate_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, op, a, out_ready,
    input  in_ready, out_valid, z, zero, ovf
  );

  modport slave (
    input  in_valid, op, a, out_ready,
    output in_ready, out_valid, z, zero, ovf
  );
endinterface

// File: rtl/bserial_negate_unit.sv
// Byte-serial WIDTH-bit inverter/negator: one 8-bit NOT slice per cycle with a
// chained +1 carry, so op=1 yields the two's complement of the latched operand.
module bserial_negate_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  bserial_negate_unit_if.slave bus
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CNTW   = $clog2(NBYTES + 1);
  // cnt reaching NBYTES marks the extra RUN cycle that settles zero from the full z.
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NBYTES);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] z_q;
  logic [CNTW-1:0]  cnt_q;
  logic             carry_q;
  logic             zero_q;
  logic             ovf_q;
  logic [7:0]       byte_res;
  logic             carry_next;
  logic             accept;

  assign accept     = (state_q == StIdle) && bus.in_valid;
  // Low operand byte is always a_q[7:0]; a_q shifts right as bytes retire.
  assign byte_res   = ~a_q[7:0] + {7'b0, carry_q};
  assign carry_next = carry_q & (a_q[7:0] == 8'h00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state: accept in IDLE, walk the bytes in RUN, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.in_valid) state_d = StRun;
      StRun:   if (cnt_q == LAST_CNT) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: latch on accept, then build z low byte first by shifting in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      carry_q <= bus.op;
      cnt_q   <= '0;
      ovf_q   <= bus.op & (bus.a == MIN_NEG);
    end else if (state_q == StRun) begin
      if (cnt_q != LAST_CNT) begin
        z_q     <= {byte_res, z_q[WIDTH-1:8]};
        a_q     <= {8'h00, a_q[WIDTH-1:8]};
        carry_q <= carry_next;
        cnt_q   <= cnt_q + CNTW'(1);
      end else begin
        zero_q  <= (z_q == '0);
      end
    end
  end

  // Outputs: handshake flags decoded from state, result straight from registers.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.z         = z_q;
    bus.zero      = zero_q;
    bus.ovf       = ovf_q;
  end

endmodule

// File: tb/tb_bserial_negate_unit.sv
// Directed bench for bserial_negate_unit: hand-computed NOT/negate vectors,
// handshake timing, stall in DONE, mid-run reset and back-to-back issue.
module tb_bserial_negate_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bserial_negate_unit_if #(.WIDTH(32)) bus ();

  bserial_negate_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc      = 0;
  logic [31:0] res_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Results consumed at the coming edge (out_valid & out_ready seen mid-cycle).
  always @(negedge clk) if (bus.out_valid && bus.out_ready) res_q.push_back(bus.z);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic op, input logic [31:0] a, input string tag);
    check({tag, "_in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = ~op;
    bus.a        = ~a;
    check({tag, "_in_ready_run"}, bus.in_ready, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] ez,
                        input logic ezero, input logic eovf, input string tag);
    int lat;
    issue(op, a, tag);
    wait_done(lat);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_z"}, bus.z, ez);
    check({tag, "_zero"}, bus.zero, ezero);
    check({tag, "_ovf"}, bus.ovf, eovf);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, bus.out_valid, 0);
    check({tag, "_z_held"}, bus.z, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int unsigned acc[3];
    logic [31:0] va[3];
    logic        vop[3];
    logic [31:0] vz[3];
    int          guard;

    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.a         = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_z", bus.z, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic NOT / negate vectors.
    run_op(1'b0, 32'h0F0F00FF, 32'hF0F0FF00, 1'b0, 1'b0, "not_0f0f00ff");
    run_op(1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, "neg_1");
    run_op(1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, "neg_0");
    run_op(1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b1, "neg_minneg");
    run_op(1'b1, 32'h00000100, 32'hFFFFFF00, 1'b0, 1'b0, "neg_100");
    run_op(1'b1, 32'h0000FF00, 32'hFFFF0100, 1'b0, 1'b0, "neg_ff00");
    run_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "neg_m1");
    run_op(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, "not_minneg");

    // Stall in DONE with a pending operand that must wait for IDLE.
    issue(1'b0, 32'hFFFFFFFF, "stall");
    wait_done(lat);
    check("stall_latency", lat, 5);
    bus.in_valid = 1'b1;
    bus.op       = 1'b0;
    bus.a        = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_z", bus.z, 32'h00000000);
      check("stall_in_ready", bus.in_ready, 0);
    end
    check("stall_zero", bus.zero, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("stall_release_out_valid", bus.out_valid, 0);
    check("stall_release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("stall_taken_in_ready", bus.in_ready, 0);
    wait_done(lat);
    check("stall_next_latency", lat, 5);
    check("stall_next_z", bus.z, 32'hEDCBA987);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset asserted after byte 2 of a run discards the operation.
    issue(1'b1, 32'h12345678, "rst_run");
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_run_out_valid", bus.out_valid, 0);
    check("rst_run_z", bus.z, 0);
    check("rst_run_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b1, 32'h00000005, 32'hFFFFFFFB, 1'b0, 1'b0, "after_rst");

    // Back-to-back issue with out_ready held high.
    va[0] = 32'h00000000; vop[0] = 1'b0; vz[0] = 32'hFFFFFFFF;
    va[1] = 32'h00000002; vop[1] = 1'b1; vz[1] = 32'hFFFFFFFE;
    va[2] = 32'h7FFFFFFF; vop[2] = 1'b1; vz[2] = 32'h80000001;
    res_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = vop[i];
      bus.a        = va[i];
      acc[i]       = 0;
      guard        = 0;
      while (!bus.in_ready && guard < 20) begin
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      acc[i] = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (res_q.size() < 3 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    bus.out_ready = 1'b0;
    check("b2b_count", res_q.size(), 3);
    check("b2b_interval_01", acc[1] - acc[0], 7);
    check("b2b_interval_12", acc[2] - acc[1], 7);
    for (int i = 0; i < 3; i++) begin
      if (i < res_q.size()) check($sformatf("b2b_z%0d", i), res_q[i], vz[i]);
      else check($sformatf("b2b_z%0d_missing", i), 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
